// File: rtl/riscv_zero_fetch.sv
// riscv_zero_fetch: fetch PC, credit-limited imem requests, in-order responses buffered in a FIFO for decode.
module riscv_zero_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] pc_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] fetch_pc, resp_pc, target_pc;
  logic [CW-1:0] outstanding, drop, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] data_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [CW:0] inflight;
  logic req_fire, push, pop, nonempty;
  // Outstanding plus buffered entries never exceed DEPTH, so responses need no backpressure.
  assign inflight = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = !reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_resp_valid && drop == '0 && !redirect_valid;
  assign nonempty = count != '0;
  assign inst_valid = !reset && nonempty && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign inst_data = (reset || !nonempty) ? 32'h0 : data_mem[rd_ptr];
  assign pc_out = (reset || !nonempty) ? 32'h0 : pc_mem[rd_ptr];
  assign target_pc = {redirect_pc[31:2], 2'b00};
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc <= target_pc;
        drop <= outstanding - CW'(imem_resp_valid);
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_resp_valid && drop != '0) drop <= drop - CW'(1);
        if (push) resp_pc <= resp_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr] <= resp_pc;
    end
  end
endmodule

// File: tb/tb_riscv_zero_fetch.sv
// tb_riscv_zero_fetch: table-driven streaming vectors plus directed stall, backpressure, redirect and reset sequences.
module tb_riscv_zero_fetch;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic clk = 0, reset = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0;
  logic redirect_valid = 0, inst_valid, inst_ready = 0;
  logic [31:0] imem_req_addr, imem_resp_data = 0, redirect_pc = 0, inst_data, pc_out;
  int checks = 0, failures = 0, accepts = 0;
  bit hold = 0;
  logic [31:0] pend[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_data[$];
  typedef struct {
    logic rdy;
    logic redir;
    logic [31:0] rpc;
    logic erv;
    logic [31:0] ea;
    logic eiv;
    logic [31:0] ep;
  } vec_t;
  vec_t tbl[13];

  riscv_zero_fetch #(.RESET_PC(BASE), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then update the memory model and decode log.
  task automatic tick();
    logic acc, popped, resp_was;
    logic [31:0] a, p, d;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    popped = inst_valid && inst_ready;
    p = pc_out;
    d = inst_data;
    resp_was = imem_resp_valid;
    @(posedge clk);
    #1;
    if (reset) begin
      pend.delete();
      imem_resp_valid = 0;
      imem_resp_data = 0;
    end else begin
      if (resp_was && pend.size() > 0) void'(pend.pop_front());
      if (acc) begin
        pend.push_back(a);
        accepts++;
      end
      if (popped) begin
        log_pc.push_back(p);
        log_data.push_back(d);
      end
      imem_resp_valid = !hold && pend.size() > 0;
      imem_resp_data = imem_resp_valid ? (pend[0] ^ KEY) : 32'h0;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    redirect_valid = 0;
    inst_ready = 0;
    imem_req_ready = 1;
    hold = 0;
    tick();
    tick();
    reset = 0;
    accepts = 0;
    log_pc.delete();
    log_data.delete();
  endtask

  task automatic row(input int i, input logic redir, input logic [31:0] rpc, input logic erv,
                     input logic [31:0] ea, input logic eiv, input logic [31:0] ep);
    tbl[i] = '{1'b1, redir, rpc, erv, ea, eiv, ep};
  endtask

  initial begin
    int n0, stale;
    bit found;
    row(0, 0, 0, 1, BASE, 0, 0);
    row(1, 0, 0, 1, BASE + 4, 0, 0);
    row(2, 0, 0, 0, 0, 1, BASE);
    row(3, 0, 0, 1, 32'h0, 1, BASE + 4);
    row(4, 0, 0, 1, 32'h4, 0, 0);
    row(5, 0, 0, 0, 0, 1, 32'h0);
    row(6, 0, 0, 1, 32'h8, 1, 32'h4);
    row(7, 0, 0, 1, 32'hC, 0, 0);
    row(8, 0, 0, 0, 0, 1, 32'h8);
    row(9, 1, 32'h41, 0, 0, 0, 0);
    row(10, 0, 0, 1, 32'h40, 0, 0);
    row(11, 0, 0, 1, 32'h44, 0, 0);
    row(12, 0, 0, 0, 0, 1, 32'h40);

    imem_req_ready = 1;
    tick();
    #1;
    chk("reset_req_valid", 32'(imem_req_valid), 0);
    chk("reset_inst_valid", 32'(inst_valid), 0);
    chk("reset_inst_data", inst_data, 0);
    chk("reset_pc_out", pc_out, 0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      inst_ready = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("row%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].erv));
      if (tbl[i].erv) chk($sformatf("row%0d_req_addr", i), imem_req_addr, tbl[i].ea);
      chk($sformatf("row%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].eiv));
      if (tbl[i].eiv) begin
        chk($sformatf("row%0d_pc_out", i), pc_out, tbl[i].ep);
        chk($sformatf("row%0d_inst_data", i), inst_data, tbl[i].ep ^ KEY);
      end
      tick();
    end
    redirect_valid = 0;

    // Decode stall then release: no loss, no duplication.
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    chk("stall_accepts", 32'(accepts), 2);
    chk("stall_inst_valid", 32'(inst_valid), 1);
    chk("stall_head_pc", pc_out, BASE);
    inst_ready = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_log_size_ok", 32'(log_pc.size() >= 6), 1);
    for (int i = 0; i < 6 && i < log_pc.size(); i++) begin
      chk($sformatf("stall_pc%0d", i), log_pc[i], BASE + 32'(4 * i));
      chk($sformatf("stall_data%0d", i), log_data[i], (BASE + 32'(4 * i)) ^ KEY);
    end

    // Memory backpressure on a pending request at 0x8.
    do_reset();
    inst_ready = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (imem_req_valid && imem_req_addr == 32'h8) found = 1;
      else tick();
    end
    chk("bp_reached_addr8", 32'(found), 1);
    imem_req_ready = 0;
    n0 = accepts;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_addr_hold%0d", i), imem_req_addr, 32'h8);
      chk($sformatf("bp_valid_hold%0d", i), 32'(imem_req_valid), 1);
    end
    chk("bp_no_accept", 32'(accepts), 32'(n0));
    imem_req_ready = 1;
    tick();
    chk("bp_accept_on_ready", 32'(accepts), 32'(n0 + 1));
    chk("bp_addr_advance", imem_req_addr, 32'hC);

    // Redirect flush with two requests outstanding.
    do_reset();
    inst_ready = 1;
    hold = 1;
    redirect_valid = 1;
    redirect_pc = 32'h10;
    tick();
    redirect_valid = 0;
    tick();
    tick();
    #1;
    chk("flush_two_outstanding", 32'(accepts), 2);
    chk("flush_credit_full", 32'(imem_req_valid), 0);
    hold = 0;
    redirect_valid = 1;
    redirect_pc = 32'h103;
    #1;
    chk("flush_no_req_on_redirect", 32'(imem_req_valid), 0);
    tick();
    redirect_valid = 0;
    #1;
    chk("flush_still_waiting", 32'(imem_req_valid), 0);
    tick();
    chk("flush_req_valid", 32'(imem_req_valid), 1);
    chk("flush_req_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 10 && log_pc.size() == 0; i++) tick();
    chk("flush_got_inst", 32'(log_pc.size() > 0), 1);
    if (log_pc.size() > 0) begin
      chk("flush_first_pc", log_pc[0], 32'h100);
      chk("flush_first_data", log_data[0], 32'h100 ^ KEY);
    end
    stale = 0;
    foreach (log_pc[i]) if (log_pc[i] == 32'h10 || log_pc[i] == 32'h14) stale++;
    chk("flush_no_stale", 32'(stale), 0);

    // Redirect coincident with a response and a would-be pop.
    do_reset();
    inst_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("coin_pre_inst_valid", 32'(inst_valid), 1);
    chk("coin_pre_pc", pc_out, 32'h0);
    log_pc.delete();
    log_data.delete();
    redirect_valid = 1;
    redirect_pc = 32'h202;
    #1;
    chk("coin_inst_valid_low", 32'(inst_valid), 0);
    chk("coin_req_valid_low", 32'(imem_req_valid), 0);
    tick();
    redirect_valid = 0;
    #1;
    chk("coin_req_valid", 32'(imem_req_valid), 1);
    chk("coin_req_addr", imem_req_addr, 32'h200);
    chk("coin_fifo_cleared", 32'(inst_valid), 0);
    for (int i = 0; i < 10 && log_pc.size() == 0; i++) tick();
    chk("coin_got_inst", 32'(log_pc.size() > 0), 1);
    if (log_pc.size() > 0) begin
      chk("coin_first_pc", log_pc[0], 32'h200);
      chk("coin_first_data", log_data[0], 32'h200 ^ KEY);
    end

    // Reset with the FIFO full.
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("rst_pre_full_valid", 32'(inst_valid), 1);
    reset = 1;
    #1;
    chk("rst_hi_inst_valid", 32'(inst_valid), 0);
    chk("rst_hi_req_valid", 32'(imem_req_valid), 0);
    chk("rst_hi_inst_data", inst_data, 0);
    chk("rst_hi_pc_out", pc_out, 0);
    tick();
    reset = 0;
    #1;
    chk("rst_post_inst_valid", 32'(inst_valid), 0);
    chk("rst_post_req_valid", 32'(imem_req_valid), 1);
    chk("rst_post_req_addr", imem_req_addr, BASE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
